// File: rtl/cdb_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cdb_arbiter_pkg: shared CDB constants and source indices  Rev 1.0  |
// +--------------------------------------------------------------------+
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH      = 4;
  localparam int CDB_DATA_WIDTH = 32;
  localparam int NUM_CDB_SRC    = 3;
  localparam int CDB_SRC_W      = 2;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int CDB_CNT_W      = 2;

  typedef enum logic [CDB_SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BRU = 2'd2
  } cdb_src_e;

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cdb_src_fifo: 2-entry in-order result FIFO with flush clear Rev 1.0 |
// +--------------------------------------------------------------------+
module cdb_src_fifo #(
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::CDB_DATA_WIDTH
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   clr,
  input  logic                                   push,
  input  logic                                   pop,
  input  logic [ROB_WIDTH-1:0]                   push_rob_id,
  input  logic [DATA_WIDTH-1:0]                  push_data,
  output logic [cdb_arbiter_pkg::CDB_CNT_W-1:0]  count,
  output logic [ROB_WIDTH-1:0]                   head_rob_id,
  output logic [DATA_WIDTH-1:0]                  head_data
);
  import cdb_arbiter_pkg::*;

  logic [CDB_CNT_W-1:0]  count_q, count_d;
  logic [ROB_WIDTH-1:0]  rob0_q, rob0_d, rob1_q, rob1_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;

  // Slot 0 is always the head; a pop shifts slot 1 down.
  always_comb begin
    count_d = count_q;
    rob0_d  = rob0_q;
    rob1_d  = rob1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (clr) begin
      count_d = '0;
    end else if (pop) begin
      rob0_d  = rob1_q;
      data0_d = data1_q;
      if (push) begin
        if (count_q == CDB_CNT_W'(1)) begin
          rob0_d  = push_rob_id;
          data0_d = push_data;
        end else begin
          rob1_d  = push_rob_id;
          data1_d = push_data;
        end
      end else begin
        count_d = count_q - CDB_CNT_W'(1);
      end
    end else if (push) begin
      if (count_q == '0) begin
        rob0_d  = push_rob_id;
        data0_d = push_data;
      end else begin
        rob1_d  = push_rob_id;
        data1_d = push_data;
      end
      count_d = count_q + CDB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
      rob0_q  <= '0;
      rob1_q  <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      count_q <= count_d;
      rob0_q  <= rob0_d;
      rob1_q  <= rob1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign count       = count_q;
  assign head_rob_id = rob0_q;
  assign head_data   = data0_q;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cdb_arbiter: round-robin serialiser of results onto the CDB Rev 1.0 |
// +--------------------------------------------------------------------+
module cdb_arbiter #(
  parameter int NUM_SRC    = cdb_arbiter_pkg::NUM_CDB_SRC,
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::CDB_DATA_WIDTH,
  parameter int SRC_W      = cdb_arbiter_pkg::CDB_SRC_W
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush,
  input  logic [NUM_SRC-1:0]              src_valid,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*ROB_WIDTH-1:0]    src_rob_id,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  output logic                            broadcast_en,
  output logic [SRC_W-1:0]                broadcast_src,
  output logic [ROB_WIDTH-1:0]            broadcast_rob_id,
  output logic [DATA_WIDTH-1:0]           broadcast_data
);
  import cdb_arbiter_pkg::*;

  logic                  advance;
  logic [NUM_SRC-1:0]    fifo_push;
  logic [NUM_SRC-1:0]    fifo_pop;
  logic [NUM_SRC-1:0]    fifo_nonempty;
  logic [CDB_CNT_W-1:0]  fifo_count [NUM_SRC];
  logic [ROB_WIDTH-1:0]  head_rob   [NUM_SRC];
  logic [DATA_WIDTH-1:0] head_data  [NUM_SRC];

  logic                  grant_valid;
  logic [SRC_W-1:0]      grant_idx;
  logic [SRC_W:0]        cand;

  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  bcast_en_q, bcast_en_d;
  logic [SRC_W-1:0]      bcast_src_q, bcast_src_d;
  logic [ROB_WIDTH-1:0]  bcast_rob_q, bcast_rob_d;
  logic [DATA_WIDTH-1:0] bcast_data_q, bcast_data_d;

  assign advance = rdy_in & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_fifo
      // Ready depends only on the registered count, never on this cycle's pop.
      assign src_ready[gi]     = (fifo_count[gi] < CDB_CNT_W'(CDB_FIFO_DEPTH));
      assign fifo_nonempty[gi] = (fifo_count[gi] != '0);
      assign fifo_push[gi]     = advance & src_valid[gi] & src_ready[gi];
      assign fifo_pop[gi]      = advance & grant_valid & (grant_idx == SRC_W'(gi));

      cdb_src_fifo #(
        .ROB_WIDTH  (ROB_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clr         (rdy_in & flush),
        .push        (fifo_push[gi]),
        .pop         (fifo_pop[gi]),
        .push_rob_id (src_rob_id[gi*ROB_WIDTH +: ROB_WIDTH]),
        .push_data   (src_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .count       (fifo_count[gi]),
        .head_rob_id (head_rob[gi]),
        .head_data   (head_data[gi])
      );
    end
  endgenerate

  // Scan from rr_ptr with wraparound; the first occupied FIFO wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_SRC)) begin
        cand = cand - (SRC_W+1)'(NUM_SRC);
      end
      if (!grant_valid && fifo_nonempty[cand[SRC_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    bcast_en_d   = bcast_en_q;
    bcast_src_d  = bcast_src_q;
    bcast_rob_d  = bcast_rob_q;
    bcast_data_d = bcast_data_q;
    if (rdy_in) begin
      if (flush) begin
        rr_ptr_d   = '0;
        bcast_en_d = 1'b0;
      end else if (grant_valid) begin
        bcast_en_d   = 1'b1;
        bcast_src_d  = grant_idx;
        bcast_rob_d  = head_rob[grant_idx];
        bcast_data_d = head_data[grant_idx];
        rr_ptr_d     = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + SRC_W'(1);
      end else begin
        bcast_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q     <= '0;
      bcast_en_q   <= 1'b0;
      bcast_src_q  <= '0;
      bcast_rob_q  <= '0;
      bcast_data_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      bcast_en_q   <= bcast_en_d;
      bcast_src_q  <= bcast_src_d;
      bcast_rob_q  <= bcast_rob_d;
      bcast_data_q <= bcast_data_d;
    end
  end

  assign broadcast_en     = bcast_en_q;
  assign broadcast_src    = bcast_src_q;
  assign broadcast_rob_id = bcast_rob_q;
  assign broadcast_data   = bcast_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cdb_arbiter: scoreboard bench for cdb_arbiter           Rev 1.0 |
// +--------------------------------------------------------------------+
module tb_cdb_arbiter;
  localparam int NS = 3;

  typedef struct packed {
    logic [1:0]  src;
    logic [3:0]  rob;
    logic [31:0] data;
  } bc_t;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [11:0] src_rob_id = '0;
  logic [95:0] src_data = '0;
  logic [2:0]  src_ready;
  logic        bcast_en;
  logic [1:0]  bcast_src;
  logic [3:0]  bcast_rob;
  logic [31:0] bcast_data;

  cdb_arbiter dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .rdy_in           (rdy),
    .flush            (flush),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .src_rob_id       (src_rob_id),
    .src_data         (src_data),
    .broadcast_en     (bcast_en),
    .broadcast_src    (bcast_src),
    .broadcast_rob_id (bcast_rob),
    .broadcast_data   (bcast_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-source queues, a rotating start index, and the last broadcast.
  ent_t mq [NS][$];
  bc_t  exp_q[$];
  bc_t  m_last = '0;
  int   m_rr = 0;
  bit   m_en = 1'b0;
  bit   live = 1'b0;
  int   m_g;
  bit [2:0] m_acc;
  int   gcnt [NS];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      exp_q.delete();
      m_rr   = 0;
      m_en   = 1'b0;
      m_last = '0;
      live   = 1'b0;
    end else begin
      live = rdy;
      if (rdy) begin
        if (flush) begin
          for (int i = 0; i < NS; i++) mq[i].delete();
          m_en = 1'b0;
          m_rr = 0;
        end else begin
          m_g = -1;
          for (int k = 0; k < NS; k++) begin
            if (m_g < 0 && mq[(m_rr + k) % NS].size() > 0) m_g = (m_rr + k) % NS;
          end
          for (int i = 0; i < NS; i++) m_acc[i] = src_valid[i] && (mq[i].size() < 2);
          if (m_g >= 0) begin
            ent_t e;
            e = mq[m_g].pop_front();
            m_last = '{src: 2'(m_g), rob: e.rob, data: e.data};
            exp_q.push_back(m_last);
            m_en = 1'b1;
            m_rr = (m_g + 1) % NS;
          end else begin
            m_en = 1'b0;
          end
          for (int i = 0; i < NS; i++) begin
            if (m_acc[i]) mq[i].push_back('{rob: src_rob_id[i*4 +: 4], data: src_data[i*32 +: 32]});
          end
        end
      end
    end
  end

  // Monitor: a fresh broadcast pops the scoreboard; otherwise outputs must hold.
  always @(negedge clk) begin
    bc_t e;
    chk("bcast_en", 64'(bcast_en), 64'(m_en));
    for (int i = 0; i < NS; i++) chk("src_ready", 64'(src_ready[i]), 64'(mq[i].size() < 2));
    if (bcast_en) chk("src_range", 64'(bcast_src < 2'(NS)), 64'(1));
    if (live && bcast_en) begin
      chk("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bcast_src", 64'(bcast_src), 64'(e.src));
        chk("bcast_rob", 64'(bcast_rob), 64'(e.rob));
        chk("bcast_data", 64'(bcast_data), 64'(e.data));
        gcnt[e.src]++;
      end
    end else begin
      chk("hold_src", 64'(bcast_src), 64'(m_last.src));
      chk("hold_rob", 64'(bcast_rob), 64'(m_last.rob));
      chk("hold_data", 64'(bcast_data), 64'(m_last.data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [3:0] r, input logic [31:0] d);
    src_valid[i] = v;
    src_rob_id[i*4 +: 4] = r;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic all_random();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'($urandom), $urandom);
  endtask

  task automatic drain(input int n);
    src_valid = '0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_en", 64'(bcast_en), 64'(0));
    chk("rst_ready", 64'(src_ready), 64'(3'b111));
    chk("rst_rob", 64'(bcast_rob), 64'(0));
    chk("rst_data", 64'(bcast_data), 64'(0));
    rst = 1'b0;
    tick();

    // Single LSB result: visible two edges after the push.
    set_src(1, 1'b1, 4'd5, 32'hDEADBEEF);
    tick();
    src_valid = '0;
    chk("t1_lat_en", 64'(bcast_en), 64'(0));
    tick();
    chk("t1_en", 64'(bcast_en), 64'(1));
    chk("t1_src", 64'(bcast_src), 64'(1));
    chk("t1_rob", 64'(bcast_rob), 64'(5));
    chk("t1_data", 64'(bcast_data), 64'(32'hDEADBEEF));
    tick();
    chk("t1_pulse", 64'(bcast_en), 64'(0));

    // Flush resets the pointer, then all three push together.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'(i + 1), 32'(32'h100 + i));
    tick();
    src_valid = '0;
    for (int i = 0; i < NS; i++) begin
      tick();
      chk("t2_en", 64'(bcast_en), 64'(1));
      chk("t2_src", 64'(bcast_src), 64'(i));
      chk("t2_rob", 64'(bcast_rob), 64'(i + 1));
    end
    tick();
    chk("t2_idle", 64'(bcast_en), 64'(0));

    // Back-to-back pushes from one source stay in order.
    set_src(0, 1'b1, 4'd7, 32'h7777);
    tick();
    set_src(0, 1'b1, 4'd8, 32'h8888);
    tick();
    src_valid = '0;
    chk("t3_first", 64'(bcast_rob), 64'(7));
    tick();
    chk("t3_second", 64'(bcast_rob), 64'(8));
    drain(3);

    // Saturation: every source keeps getting served.
    for (int i = 0; i < NS; i++) gcnt[i] = 0;
    repeat (30) begin
      all_random();
      tick();
    end
    for (int i = 0; i < NS; i++) chk("t4_no_starve", 64'(gcnt[i] >= 9), 64'(1));
    drain(4);

    // Flush with queued entries; flushed tags must never reach the bus.
    all_random();
    repeat (2) tick();
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 4'hF, 32'hBAD0_0000 + 32'(i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src_valid = '0;
    chk("t5_en", 64'(bcast_en), 64'(0));
    chk("t5_ready", 64'(src_ready), 64'(3'b111));
    drain(4);

    // Freeze mid-stream with valid offers that must be ignored.
    all_random();
    repeat (3) tick();
    chk("t6_busy", 64'(bcast_en), 64'(1));
    rdy = 1'b0;
    repeat (3) begin
      all_random();
      tick();
    end
    rdy = 1'b1;
    drain(6);

    // Randomized traffic with occasional flush and freeze.
    repeat (300) begin
      for (int i = 0; i < NS; i++) set_src(i, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      flush = ($urandom_range(0, 39) == 0);
      rdy   = ($urandom_range(0, 7) != 0);
      tick();
    end
    flush = 1'b0;
    rdy   = 1'b1;

    // Asynchronous reset between edges clears the bus at once.
    all_random();
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", 64'(bcast_en), 64'(0));
    chk("async_rst_ready", 64'(src_ready), 64'(3'b111));
    rst = 1'b0;
    drain(10);

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
